// File: rtl/axo_muldiv_seq.sv
// Sequential RV M-extension unit: one result bit per clock (shift-add multiply, restoring divide
// on magnitudes, sign fix-up at the end). Define AXO_MULDIV_EARLY_OUT_EN to let trivial ops skip CALC.
module axo_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_lhs,
  input  logic [XLEN-1:0] req_rhs,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_res,
  output logic            busy
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              neg;
  logic              force_en;
  logic [XLEN-1:0]   force_val;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   hi, lo;

  logic              accept, early;
  logic              req_div, lhs_signed, rhs_signed, lhs_neg, rhs_neg;
  logic              div_zero, div_ovf, mul_zero;
  logic [XLEN-1:0]   lhs_mag, rhs_mag, special_res;

  logic [XLEN:0]     add_sum, rem_shift, rem_diff;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   dsel, dsel_fix, result;

  // Request decode: signedness from funct3, magnitudes and RV special cases.
  always_comb begin
    req_div     = req_funct3[2];
    lhs_signed  = req_div ? !req_funct3[0] : (req_funct3[1:0] != 2'b11);
    rhs_signed  = req_div ? !req_funct3[0] : !req_funct3[1];
    lhs_neg     = lhs_signed & req_lhs[XLEN-1];
    rhs_neg     = rhs_signed & req_rhs[XLEN-1];
    lhs_mag     = lhs_neg ? -req_lhs : req_lhs;
    rhs_mag     = rhs_neg ? -req_rhs : req_rhs;
    div_zero    = req_div && (req_rhs == '0);
    div_ovf     = req_div && !req_funct3[0] && (req_lhs == MIN_NEG) && (&req_rhs);
    mul_zero    = !req_div && ((req_lhs == '0) || (req_rhs == '0));
    special_res = '0;
    if (div_zero)     special_res = req_funct3[1] ? req_lhs : '1;
    else if (div_ovf) special_res = req_funct3[1] ? '0 : req_lhs;
  end

  assign accept = req_valid && (state == IDLE) && !flush;

`ifdef AXO_MULDIV_EARLY_OUT_EN
  assign early = div_zero || div_ovf || mul_zero;
`else
  assign early = 1'b0;
`endif

  // NOTE: every state register updates with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = early ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // One iteration: multiply shifts {hi,lo} right adding opb on lo[0];
  // divide shifts the dividend from lo into hi and keeps the trial subtraction if it fits.
  always_comb begin
    add_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    rem_shift = {hi, lo[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opb};
    if (op[2]) begin
      if (!rem_diff[XLEN]) begin
        hi_nxt = rem_diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = rem_shift[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_sum[XLEN:1];
      lo_nxt = {add_sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg ? -prod : prod;
    dsel     = op[1] ? hi_nxt : lo_nxt;
    dsel_fix = neg ? -dsel : dsel;
    if (force_en)              result = force_val;
    else if (op[2])            result = dsel_fix;
    else if (op[1:0] == 2'b00) result = prod_fix[XLEN-1:0];
    else                       result = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      op        <= '0;
      neg       <= 1'b0;
      force_en  <= 1'b0;
      force_val <= '0;
      opb       <= '0;
      hi        <= '0;
      lo        <= '0;
      resp_res  <= '0;
    end else if (accept) begin
      cnt       <= CNT_W'(XLEN - 1);
      op        <= req_funct3;
      neg       <= (req_div && req_funct3[1]) ? lhs_neg : (lhs_neg ^ rhs_neg);
      force_en  <= div_zero || div_ovf || mul_zero;
      force_val <= special_res;
      opb       <= req_div ? rhs_mag : lhs_mag;
      lo        <= req_div ? lhs_mag : rhs_mag;
      hi        <= '0;
      if (early) resp_res <= special_res;
    end else if ((state == CALC) && !flush) begin
      cnt <= cnt - 1'b1;
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      if (cnt == '0) resp_res <= result;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_axo_muldiv_seq.sv
// Bench for axo_muldiv_seq: directed RV M-extension cases, backpressure/flush/reset steps and
// random ops on XLEN=32 and XLEN=64 instances, checked against a wide-integer arithmetic model.
module tb_axo_muldiv_seq;
`ifdef AXO_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, resp_ready;
  logic [2:0]  funct3;
  logic [63:0] lhs, rhs;
  logic        valid_n, valid_w;
  logic        ready_n, rvalid_n, busy_n;
  logic [31:0] res_n;
  logic        ready_w, rvalid_w, busy_w;
  logic [63:0] res_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axo_muldiv_seq #(.XLEN(32)) dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(valid_n), .req_ready(ready_n), .req_funct3(funct3),
    .req_lhs(lhs[31:0]), .req_rhs(rhs[31:0]),
    .resp_valid(rvalid_n), .resp_ready(resp_ready), .resp_res(res_n), .busy(busy_n)
  );

  axo_muldiv_seq #(.XLEN(64)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(valid_w), .req_ready(ready_w), .req_funct3(funct3),
    .req_lhs(lhs), .req_rhs(rhs),
    .resp_valid(rvalid_w), .resp_ready(resp_ready), .resp_res(res_w), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact arithmetic on 130-bit signed integers following the RV M rules.
  function automatic logic [63:0] model(input int xl, input logic [2:0] f,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0]         mask;
    logic signed [129:0] sa, sb, r, lim;
    logic [129:0]        t;
    bit                  a_s, b_s;
    mask = (xl == 64) ? '1 : 64'hFFFF_FFFF;
    a_s  = f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    b_s  = f inside {3'd0, 3'd1, 3'd4, 3'd6};
    sa   = $signed({66'd0, a});
    sb   = $signed({66'd0, b});
    if (a_s && a[xl-1]) sa = sa - (130'sd1 <<< xl);
    if (b_s && b[xl-1]) sb = sb - (130'sd1 <<< xl);
    lim = -(130'sd1 <<< (xl - 1));
    if (!f[2]) begin
      r = sa * sb;
      if (f[1:0] != 2'b00) r = r >>> xl;
    end else if (b == 64'd0) begin
      r = f[1] ? sa : -130'sd1;
    end else if (a_s && (sa == lim) && (sb == -130'sd1)) begin
      r = f[1] ? 130'sd0 : sa;
    end else begin
      r = f[1] ? (sa % sb) : (sa / sb);
    end
    t = r;
    return t[63:0] & mask;
  endfunction

  // Edges after the accepting edge until resp_valid is seen; early-out results are already
  // visible right after the accepting edge.
  function automatic int exp_latency(input int xl, input logic [2:0] f,
                                     input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv;
    bit          special;
    mask    = (xl == 64) ? '1 : 64'hFFFF_FFFF;
    minv    = 64'd1 << (xl - 1);
    special = (f[2] && (b == 64'd0)) || (f[2] && !f[0] && (a == minv) && (b == mask)) ||
              (!f[2] && ((a == 64'd0) || (b == 64'd0)));
    return (EARLY && special) ? 0 : xl;
  endfunction

  function automatic logic obs_valid(input bit wide);
    return wide ? rvalid_w : rvalid_n;
  endfunction

  function automatic logic obs_ready(input bit wide);
    return wide ? ready_w : ready_n;
  endfunction

  function automatic logic [63:0] obs_res(input bit wide);
    return wide ? res_w : {32'd0, res_n};
  endfunction

  // Called #1 after a posedge with the unit idle; returns #1 after the accepting edge.
  task automatic issue(input bit wide, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    funct3  = f;
    lhs     = a;
    rhs     = b;
    valid_n = !wide;
    valid_w = wide;
    @(posedge clk); #1;
    valid_n = 1'b0;
    valid_w = 1'b0;
    funct3  = 3'($urandom);
    lhs     = {$urandom, $urandom};
    rhs     = {$urandom, $urandom};
  endtask

  task automatic wait_valid(input bit wide, input int limit, output int lat);
    lat = 0;
    while (!obs_valid(wide) && (lat < limit)) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input bit wide, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input string tag);
    int xl, lat;
    xl = wide ? 64 : 32;
    check({tag, "_ready"}, 64'(obs_ready(wide)), 64'd1);
    issue(wide, f, a, b);
    wait_valid(wide, 2 * xl + 8, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_latency(xl, f, a, b)));
    check({tag, "_res"}, obs_res(wide), exp);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_drain"}, 64'(obs_valid(wide)), 64'd0);
  endtask

  task automatic rand_op(input bit wide, input int idx);
    logic [2:0]  f;
    logic [63:0] a, b, mask;
    int          xl;
    xl   = wide ? 64 : 32;
    mask = wide ? '1 : 64'hFFFF_FFFF;
    f    = 3'($urandom);
    a    = {$urandom, $urandom} & mask;
    b    = {$urandom, $urandom} & mask;
    case ($urandom_range(0, 9))
      0: b = 64'd0;
      1: begin a = 64'd1 << (xl - 1); b = mask; end
      2: a = 64'd0;
      3: b = 64'd1;
      4: b = b >> $urandom_range(1, xl - 1);
      default: ;
    endcase
    run_op(wide, f, a, b, model(xl, f, a, b), $sformatf("rnd%0d_%0d_f%0d", xl, idx, f));
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] held;
    rst_n = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    valid_n = 1'b0; valid_w = 1'b0; funct3 = 3'd0; lhs = '0; rhs = '0;

    #3;
    check("rst_ready_n", 64'(ready_n), 64'd1);
    check("rst_valid_n", 64'(rvalid_n), 64'd0);
    check("rst_res_n",   64'(res_n), 64'd0);
    check("rst_busy_n",  64'(busy_n), 64'd0);
    check("rst_ready_w", 64'(ready_w), 64'd1);
    check("rst_busy_w",  64'(busy_w), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 3'b000, 64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFEB, "mul_7_m3");
    run_op(0, 3'b001, 64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFFF, "mulh_7_m3");
    run_op(0, 3'b011, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFE, "mulhu_max");
    run_op(0, 3'b010, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhsu_m1");
    run_op(0, 3'b100, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFD, "div_m7_2");
    run_op(0, 3'b110, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFF, "rem_m7_2");
    run_op(0, 3'b101, 64'd100,        64'd7,         64'd14,        "divu_100_7");
    run_op(0, 3'b111, 64'd100,        64'd7,         64'd2,         "remu_100_7");
    run_op(0, 3'b100, 64'h8000_0000,  64'hFFFF_FFFF, 64'h8000_0000, "div_ovf");
    run_op(0, 3'b110, 64'h8000_0000,  64'hFFFF_FFFF, 64'd0,         "rem_ovf");
    run_op(0, 3'b101, 64'd5,          64'd0,         64'hFFFF_FFFF, "divu_by0");
    run_op(0, 3'b111, 64'd5,          64'd0,         64'd5,         "remu_by0");
    run_op(0, 3'b100, 64'hFFFF_FFF9,  64'd0,         64'hFFFF_FFFF, "div_by0");
    run_op(0, 3'b110, 64'hFFFF_FFF9,  64'd0,         64'hFFFF_FFF9, "rem_by0");
    run_op(0, 3'b000, 64'd0,          64'd12345,     64'd0,         "mul_zero");

    // Backpressure: result held 5 cycles; a request presented in DONE is never taken.
    issue(0, 3'b000, 64'd12345, 64'd678);
    wait_valid(0, 72, lat);
    check("bp_lat", 64'(lat), 64'd32);
    check("bp_res", 64'(res_n), 64'd8369910);
    held    = res_n;
    funct3  = 3'b000; lhs = 64'd3; rhs = 64'd3; valid_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_res", i), 64'(res_n), 64'(held));
      check($sformatf("bp_hold%0d_ready", i), 64'(ready_n), 64'd0);
      check($sformatf("bp_hold%0d_valid", i), 64'(rvalid_n), 64'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; valid_n = 1'b0;
    check("bp_no_accept_busy", 64'(busy_n), 64'd0);
    check("bp_no_accept_valid", 64'(rvalid_n), 64'd0);

    // Flush in IDLE wins over a pending request.
    valid_n = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid_n = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 64'(busy_n), 64'd0);

    // Flush at CALC cycle 10: back to IDLE and no response ever appears.
    issue(0, 3'b100, 64'd1000000, 64'd37);
    repeat (9) begin @(posedge clk); #1; end
    check("flush_calc_busy_before", 64'(busy_n), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc_busy", 64'(busy_n), 64'd0);
    check("flush_calc_ready", 64'(ready_n), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rvalid_n) seen++;
    end
    check("flush_calc_no_valid", 64'(seen), 64'd0);

    // Flush coinciding with resp_ready in DONE.
    issue(0, 3'b101, 64'd1000, 64'd10);
    wait_valid(0, 72, lat);
    check("flush_done_res", 64'(res_n), 64'd100);
    resp_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; flush = 1'b0;
    check("flush_done_valid", 64'(rvalid_n), 64'd0);
    check("flush_done_ready", 64'(ready_n), 64'd1);
    run_op(0, 3'b111, 64'd1000, 64'd7, 64'd6, "after_flush_remu");

    // XLEN=64 instance, including an asynchronous reset in the middle of CALC.
    run_op(1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, "w_mulhu_max2");
    issue(1, 3'b000, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    repeat (20) begin @(posedge clk); #1; end
    check("w_mid_busy", 64'(busy_w), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("w_rst_ready", 64'(ready_w), 64'd1);
    check("w_rst_valid", 64'(rvalid_w), 64'd0);
    check("w_rst_busy",  64'(busy_w), 64'd0);
    check("w_rst_res",   res_w, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 3'b000, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, "w_mul_2p32");
    run_op(1, 3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, "w_mulhu_2p32");
    run_op(1, 3'b100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, "w_div_ovf");

    for (int i = 0; i < 48; i++) rand_op(0, i);
    for (int i = 0; i < 10; i++) rand_op(1, i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
